// File: rtl/ama_riscv_dmem_responder.sv
// Single-port data memory responder: valid/ready request in, valid/ready response out, one transaction at a time.
// Optional response stall: define DMEM_RESP_STALL_EN to insert STALL_CYC wait cycles before RESP.
module ama_riscv_dmem_responder #(
   parameter int DEPTH_W   = 4096,
   parameter int STALL_CYC = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic        req_rtype,
   input  logic [1:0]  req_dtype,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic [31:0] cnt_ld,
   output logic [31:0] cnt_st,
   output logic [31:0] cnt_err
);

   localparam int AW = (DEPTH_W > 1) ? $clog2(DEPTH_W) : 1;
`ifdef DMEM_RESP_STALL_EN
   localparam int STALL_EFF = STALL_CYC;
`else
   // without the stall build the wait phase collapses to zero cycles
   localparam int STALL_EFF = STALL_CYC * 0;
`endif

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   function automatic logic req_fault(input logic [1:0] dtype, input logic [31:0] addr);
      logic f;
      case (dtype)
         2'd0:    f = 1'b0;
         2'd1:    f = addr[0];
         2'd2:    f = (addr[1:0] != 2'b00);
         default: f = 1'b1;
      endcase
      return f | ({2'b00, addr[31:2]} >= 32'(DEPTH_W));
   endfunction

   function automatic logic [3:0] lane_mask(input logic [1:0] dtype, input logic [1:0] lane);
      logic [3:0] m;
      case (dtype)
         2'd0:    m = 4'b0001 << lane;
         2'd1:    m = lane[1] ? 4'b1100 : 4'b0011;
         2'd2:    m = 4'b1111;
         default: m = 4'b0000;
      endcase
      return m;
   endfunction

   logic [31:0]   mem_r [DEPTH_W];
   state_t        state_r;
   logic [31:0]   wait_cnt_r;
   logic          req_ready_r;
   logic          rsp_valid_r;
   logic [31:0]   rsp_rdata_r;
   logic          rsp_err_r;
   logic          rtype_r;
   logic [31:0]   cnt_ld_r;
   logic [31:0]   cnt_st_r;
   logic [31:0]   cnt_err_r;

   logic          accept_s;
   logic          fault_s;
   logic          we_s;
   logic [AW-1:0] idx_s;
   logic [3:0]    be_s;
   logic [31:0]   wdata_rep_s;
   logic [31:0]   rd_word_s;

   // Acceptance decode, fault check and lane-replicated store data
   always_comb begin
      accept_s = req_valid & req_ready_r & ~rst;
      fault_s  = req_fault(req_dtype, req_addr);
      we_s     = accept_s & req_rtype & ~fault_s;
      idx_s    = req_addr[AW+1:2];
      be_s     = lane_mask(req_dtype, req_addr[1:0]);
      case (req_dtype)
         2'd0:    wdata_rep_s = {4{req_wdata[7:0]}};
         2'd1:    wdata_rep_s = {2{req_wdata[15:0]}};
         default: wdata_rep_s = req_wdata;
      endcase
      rd_word_s = mem_r[idx_s];
   end

   // Store commit in the acceptance cycle; memory contents survive reset
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (we_s && be_s[i]) begin
            mem_r[idx_s][8*i +: 8] <= wdata_rep_s[8*i +: 8];
         end
      end
   end

   // Transaction FSM with registered handshake outputs and completion counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         wait_cnt_r  <= 32'd0;
         req_ready_r <= 1'b1;
         rsp_valid_r <= 1'b0;
         rsp_rdata_r <= 32'd0;
         rsp_err_r   <= 1'b0;
         rtype_r     <= 1'b0;
         cnt_ld_r    <= 32'd0;
         cnt_st_r    <= 32'd0;
         cnt_err_r   <= 32'd0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (accept_s) begin
                  rtype_r     <= req_rtype;
                  rsp_err_r   <= fault_s;
                  rsp_rdata_r <= (fault_s || req_rtype) ? 32'd0 : rd_word_s;
                  req_ready_r <= 1'b0;
                  wait_cnt_r  <= 32'd0;
                  if (STALL_EFF == 0) begin
                     state_r     <= ST_RESP;
                     rsp_valid_r <= 1'b1;
                  end else begin
                     state_r     <= ST_WAIT;
                  end
               end
            end
            ST_WAIT: begin
               if (wait_cnt_r == 32'(STALL_EFF - 1)) begin
                  state_r     <= ST_RESP;
                  rsp_valid_r <= 1'b1;
                  wait_cnt_r  <= 32'd0;
               end else begin
                  wait_cnt_r  <= wait_cnt_r + 32'd1;
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  state_r     <= ST_IDLE;
                  rsp_valid_r <= 1'b0;
                  req_ready_r <= 1'b1;
                  if (rsp_err_r) begin
                     cnt_err_r <= cnt_err_r + 32'd1;
                  end else if (rtype_r) begin
                     cnt_st_r  <= cnt_st_r + 32'd1;
                  end else begin
                     cnt_ld_r  <= cnt_ld_r + 32'd1;
                  end
               end
            end
            default: begin
               state_r     <= ST_IDLE;
               rsp_valid_r <= 1'b0;
               req_ready_r <= 1'b1;
            end
         endcase
      end
   end

   assign req_ready = req_ready_r;
   assign rsp_valid = rsp_valid_r;
   assign rsp_rdata = rsp_rdata_r;
   assign rsp_err   = rsp_err_r;
   assign cnt_ld    = cnt_ld_r;
   assign cnt_st    = cnt_st_r;
   assign cnt_err   = cnt_err_r;

endmodule

// File: tb/tb_ama_riscv_dmem_responder.sv
// Randomized bench for ama_riscv_dmem_responder against a byte-level memory/transaction model.
module tb_ama_riscv_dmem_responder;
   localparam int DEPTH = 64;
   localparam int STALL = 2;
`ifdef DMEM_RESP_STALL_EN
   localparam int LAT = STALL + 1;
`else
   localparam int LAT = 1;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [31:0] req_addr = 32'd0;
   logic        req_rtype = 1'b0;
   logic [1:0]  req_dtype = 2'd0;
   logic [31:0] req_wdata = 32'd0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [31:0] cnt_ld, cnt_st, cnt_err;

   ama_riscv_dmem_responder #(.DEPTH_W(DEPTH), .STALL_CYC(STALL)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_rtype(req_rtype), .req_dtype(req_dtype), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .cnt_ld(cnt_ld), .cnt_st(cnt_st), .cnt_err(cnt_err)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [7:0]  mm [DEPTH*4];
   bit          mk [DEPTH*4];
   int          cyc = 0;
   bit          busy = 1'b0;
   int          acc = 0;
   bit          e_err, e_st, e_known;
   logic [31:0] e_rd;
   logic [31:0] m_ld = 32'd0, m_st = 32'd0, m_err = 32'd0;

   function automatic bit fault_m(input logic [1:0] dt, input logic [31:0] a);
      if (dt == 2'd3) return 1'b1;
      if (dt == 2'd1 && (a % 2) != 0) return 1'b1;
      if (dt == 2'd2 && (a % 4) != 0) return 1'b1;
      return (a / 4) >= DEPTH;
   endfunction

   always @(posedge clk) begin
      int nb;
      int w;
      cyc = cyc + 1;
      if (rst) begin
         busy = 1'b0;
         m_ld = 32'd0; m_st = 32'd0; m_err = 32'd0;
      end else if (busy) begin
         if ((cyc - 1) >= acc + LAT - 1 && rsp_ready) begin
            if (e_err) m_err = m_err + 32'd1;
            else if (e_st) m_st = m_st + 32'd1;
            else m_ld = m_ld + 32'd1;
            busy = 1'b0;
         end
      end else if (req_valid) begin
         busy  = 1'b1;
         acc   = cyc;
         e_err = fault_m(req_dtype, req_addr);
         e_st  = req_rtype;
         e_rd  = 32'd0;
         e_known = 1'b1;
         if (!e_err && e_st) begin
            nb = (req_dtype == 2'd0) ? 1 : (req_dtype == 2'd1) ? 2 : 4;
            for (int k = 0; k < nb; k++) begin
               mm[req_addr + k] = 8'((req_wdata >> (8 * k)) & 32'hFF);
               mk[req_addr + k] = 1'b1;
            end
         end else if (!e_err) begin
            w = int'(req_addr / 4);
            for (int k = 0; k < 4; k++) begin
               e_rd = e_rd | (32'(mm[4*w + k]) << (8 * k));
               if (!mk[4*w + k]) e_known = 1'b0;
            end
         end
      end
   end

   // single compare process, every cycle
   always @(negedge clk) begin
      bit ev;
      if (rst) begin
         chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
         chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
         chk("rst_rsp_rdata", rsp_rdata, 32'd0);
         chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
         chk("rst_cnt", cnt_ld | cnt_st | cnt_err, 32'd0);
      end else begin
         ev = busy && (cyc >= acc + LAT - 1);
         chk("req_ready", {31'd0, req_ready}, {31'd0, !busy});
         chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, ev});
         if (ev) begin
            chk("rsp_err", {31'd0, rsp_err}, {31'd0, e_err});
            if (e_known) chk("rsp_rdata", rsp_rdata, e_rd);
         end
         chk("cnt_ld", cnt_ld, m_ld);
         chk("cnt_st", cnt_st, m_st);
         chk("cnt_err", cnt_err, m_err);
      end
   end

   // ---------------- driver ----------------
   task automatic run_req(input bit rt, input logic [1:0] dt, input logic [31:0] a,
                          input logic [31:0] wd, input int hold,
                          output logic [31:0] rd, output logic er);
      int n;
      n = 0;
      while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
      if (!req_ready) chk("req_ready_timeout", 32'd0, 32'd1);
      req_valid = 1'b1; req_rtype = rt; req_dtype = dt; req_addr = a; req_wdata = wd;
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_addr = $urandom; req_wdata = $urandom;
      req_rtype = 1'($urandom); req_dtype = 2'($urandom);
      n = 0;
      while (!rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
      chk("rsp_latency", 32'(n), 32'(LAT - 1));
      rd = rsp_rdata;
      er = rsp_err;
      for (int k = 0; k < hold; k++) begin
         req_valid = 1'($urandom);
         @(posedge clk); #1;
         chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
         chk("hold_rdata", rsp_rdata, rd);
         chk("hold_err", {31'd0, rsp_err}, {31'd0, er});
         chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      chk("ready_after_hs", {31'd0, req_ready}, 32'd1);
   endtask

   initial begin
      logic [31:0] rd;
      logic        er;
      logic [1:0]  dt;
      logic [31:0] a;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk("init_req_ready", {31'd0, req_ready}, 32'd1);
      chk("init_rsp_rdata", rsp_rdata, 32'd0);

      // word store then load
      run_req(1'b1, 2'd2, 32'h10, 32'hDEADBEEF, 0, rd, er);
      run_req(1'b0, 2'd2, 32'h10, 32'h0, 0, rd, er);
      chk("lit_ld_word", rd, 32'hDEADBEEF);
      chk("lit_ld_err", {31'd0, er}, 32'd0);
      chk("lit_cnt_st", cnt_st, 32'd1);
      chk("lit_cnt_ld", cnt_ld, 32'd1);

      // byte merge
      run_req(1'b1, 2'd2, 32'h10, 32'h11223344, 1, rd, er);
      run_req(1'b1, 2'd0, 32'h13, 32'h123456AA, 0, rd, er);
      run_req(1'b0, 2'd2, 32'h10, 32'h0, 0, rd, er);
      chk("lit_byte_merge", rd, 32'hAA223344);

      // fault cases
      run_req(1'b1, 2'd1, 32'h11, 32'h0000FFFF, 0, rd, er);
      chk("lit_half_mis_err", {31'd0, er}, 32'd1);
      chk("lit_half_mis_rd", rd, 32'd0);
      run_req(1'b0, 2'd2, 32'h02, 32'h0, 0, rd, er);
      chk("lit_word_mis_err", {31'd0, er}, 32'd1);
      chk("lit_word_mis_rd", rd, 32'd0);
      run_req(1'b1, 2'd3, 32'h10, 32'h55555555, 0, rd, er);
      chk("lit_dtype3_err", {31'd0, er}, 32'd1);
      run_req(1'b1, 2'd2, 32'(DEPTH * 4), 32'h66666666, 0, rd, er);
      chk("lit_range_err", {31'd0, er}, 32'd1);
      chk("lit_cnt_err", cnt_err, 32'd4);

      // held response, also confirms memory untouched by faults
      run_req(1'b0, 2'd2, 32'h10, 32'h0, 5, rd, er);
      chk("lit_unchanged", rd, 32'hAA223344);

      // fill memory so every load has a known expectation
      for (int w = 0; w < DEPTH; w++) run_req(1'b1, 2'd2, 32'(4 * w), $urandom, 0, rd, er);

      for (int i = 0; i < 250; i++) begin
         dt = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         a  = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, DEPTH * 4 + 15))
                                          : 32'($urandom_range(0, DEPTH * 4 - 1));
         if ($urandom_range(0, 3) != 0) begin
            if (dt == 2'd1) a = a & ~32'd1;
            else if (dt == 2'd2) a = a & ~32'd3;
            else a = a;
         end
         run_req(1'($urandom), dt, a, $urandom, $urandom_range(0, 3), rd, er);
      end

      // reset mid-transaction: store stays, no response, counters cleared
      req_valid = 1'b1; req_rtype = 1'b1; req_dtype = 2'd2;
      req_addr = 32'h20; req_wdata = 32'hCAFEF00D;
      @(posedge clk); #1;
      req_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("post_rst_cnt_st", cnt_st, 32'd0);
      chk("post_rst_ready", {31'd0, req_ready}, 32'd1);
      repeat (4) @(posedge clk);
      #1 chk("post_rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
      run_req(1'b0, 2'd2, 32'h20, 32'h0, 0, rd, er);
      chk("lit_after_rst", rd, 32'hCAFEF00D);
      chk("lit_after_rst_cnt_ld", cnt_ld, 32'd1);

      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule
